// File: rtl/d_ff.sv
// Purpose: parameterised positive-edge D flip-flop with complementary outputs and synchronous active-high reset.
// Latency: D sampled on a rising CLK edge appears on Q right after that edge; Q_not follows Q combinationally.
// Backpressure: none; a new value is captured on every rising edge.
module d_ff #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_not
);

  // Stored value; left uninitialised so it powers up unknown.
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next state: reset wins over data. An unknown RST falls to the data branch
  // rather than forcing the reset value.
  always_comb begin
    q_d = D;
    if (RST) begin
      q_d = RESET_VALUE;
    end
  end

  // Capture on the rising edge only; nothing else can disturb the stored value.
  always_ff @(posedge CLK) begin
    q_q <= q_d;
  end

  assign Q     = q_q;
  // Complement is derived, never stored, so it can never disagree with Q.
  assign Q_not = ~q_q;

endmodule

// File: tb/tb_d_ff.sv
// Bench for d_ff: a 1-bit cell driven step by step, and a 4-bit register with reset value 4'hA
// run against a free-running clock with random data and random reset pulses.
module tb_d_ff;

  int checks = 0;
  int errors = 0;

  // 1-bit instance, clock driven explicitly by the scenario tasks
  logic       clk1 = 1'b0;
  logic       rst1 = 1'b0;
  logic [0:0] d1   = 1'b0;
  logic [0:0] q1;
  logic [0:0] qn1;

  // 4-bit instance, free-running clock
  logic       clk4 = 1'b0;
  logic       rst4 = 1'b0;
  logic [3:0] d4   = 4'h0;
  logic [3:0] q4;
  logic [3:0] qn4;

  d_ff #(.WIDTH(1)) dut1 (
    .CLK  (clk1),
    .RST  (rst1),
    .D    (d1),
    .Q    (q1),
    .Q_not(qn1)
  );

  d_ff #(.WIDTH(4), .RESET_VALUE(4'hA)) dut4 (
    .CLK  (clk4),
    .RST  (rst4),
    .D    (d4),
    .Q    (q4),
    .Q_not(qn4)
  );

  always #5 clk4 = ~clk4;

  // Overall time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  // Expected state of the 1-bit cell, maintained from the flip-flop rules.
  logic exp1;

  task automatic chk1(input string name, input logic eq, input logic eqn);
    // Comparison of both 1-bit outputs against the tracked expectation.
    checks++;
    if (q1 !== eq) begin
      errors++;
      $display("FAIL %s: Q=%b expected %b", name, q1, eq);
    end
    checks++;
    if (qn1 !== eqn) begin
      errors++;
      $display("FAIL %s: Q_not=%b expected %b", name, qn1, eqn);
    end
  endtask

  task automatic rise1();
    clk1 = 1'b1;
    #5;
  endtask

  task automatic fall1();
    clk1 = 1'b0;
    #5;
  endtask

  task automatic test_reset();
    rst1 = 1'b1;
    d1   = 1'b1;
    #5;
    rise1();
    exp1 = 1'b0;
    chk1("reset_1bit", exp1, ~exp1);
    fall1();
    rst1 = 1'b0;
    @(negedge clk4);
    rst4 = 1'b1;
    d4   = 4'hF;
    @(posedge clk4);
    #1;
    checks++;
    if (q4 !== 4'hA || qn4 !== 4'h5) begin
      errors++;
      $display("FAIL reset_4bit: Q=%h Q_not=%h expected Q=a Q_not=5", q4, qn4);
    end
  endtask

  task automatic test_truth_table();
    logic pd [8];
    logic pc [8];
    logic prev_clk;
    pd = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    pc = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    prev_clk = clk1;
    for (int i = 0; i < 8; i++) begin
      d1   = pd[i];
      clk1 = pc[i];
      #1;
      if (pc[i] && !prev_clk) exp1 = pd[i];
      prev_clk = pc[i];
      chk1($sformatf("table_step%0d", i), exp1, ~exp1);
      #62;
      chk1($sformatf("table_step%0d_mid", i), exp1, ~exp1);
      #62;
    end
    // The last rising edge captured D=1.
    checks++;
    if (q1 !== 1'b1) begin
      errors++;
      $display("FAIL table_final: Q=%b expected 1", q1);
    end
  endtask

  task automatic test_hold();
    fall1();
    for (int i = 0; i < 6; i++) begin
      d1 = ~d1;
      #3;
      chk1("hold_clk_low", exp1, ~exp1);
    end
    clk1 = 1'b1;
    d1   = ~exp1;
    #1;
    exp1 = d1;
    chk1("hold_then_edge", exp1, ~exp1);
    for (int i = 0; i < 4; i++) begin
      d1 = ~d1;
      #3;
      chk1("hold_clk_high", exp1, ~exp1);
    end
    d1 = ~exp1;
    fall1();
    chk1("hold_falling_edge", exp1, ~exp1);
  endtask

  task automatic test_sync_reset();
    d1 = 1'b1;
    rise1();
    exp1 = 1'b1;
    chk1("sreset_setup", exp1, ~exp1);
    fall1();
    rst1 = 1'b1;
    #5;
    chk1("sreset_midcycle_hold", 1'b1, 1'b0);
    rise1();
    exp1 = 1'b0;
    chk1("sreset_edge", exp1, ~exp1);
    for (int i = 0; i < 3; i++) begin
      fall1();
      d1 = 1'b1;
      rise1();
      chk1($sformatf("sreset_held_edge%0d", i), 1'b0, 1'b1);
    end
    fall1();
    rst1 = 1'b0;
    d1   = 1'b1;
    #3;
    chk1("release_before_edge", 1'b0, 1'b1);
    rise1();
    exp1 = 1'b1;
    chk1("release_first_edge", exp1, ~exp1);
    fall1();
  endtask

  task automatic test_width4();
    @(negedge clk4);
    rst4 = 1'b1;
    d4   = 4'h7;
    @(posedge clk4);
    #1;
    checks++;
    if (q4 !== 4'hA || qn4 !== 4'h5) begin
      errors++;
      $display("FAIL w4_reset: Q=%h Q_not=%h expected Q=a Q_not=5", q4, qn4);
    end
    @(negedge clk4);
    rst4 = 1'b0;
    d4   = 4'h3;
    #2;
    checks++;
    if (q4 !== 4'hA) begin
      errors++;
      $display("FAIL w4_hold_before_edge: Q=%h expected a", q4);
    end
    @(posedge clk4);
    #1;
    checks++;
    if (q4 !== 4'h3 || qn4 !== 4'hC) begin
      errors++;
      $display("FAIL w4_capture: Q=%h Q_not=%h expected Q=3 Q_not=c", q4, qn4);
    end
  endtask

  task automatic test_random();
    logic [3:0] exp4;
    logic       r;
    logic [3:0] d;
    int         nrst;
    nrst = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk4);
      d = 4'($urandom);
      r = ($urandom_range(0, 7) == 0);
      d4   = d;
      rst4 = r;
      // One edge later Q holds the reset value if reset was seen, otherwise the data.
      exp4 = r ? 4'hA : d;
      if (r) nrst++;
      @(posedge clk4);
      #1;
      checks++;
      if (q4 !== exp4) begin
        errors++;
        $display("FAIL random_q edge%0d: Q=%h expected %h (rst=%b d=%h)", i, q4, exp4, r, d);
      end
      checks++;
      if (qn4 !== ~exp4 || (qn4 & ~q4) !== qn4 || (q4 ^ qn4) !== 4'hF) begin
        errors++;
        $display("FAIL random_qnot edge%0d: Q_not=%h Q=%h expected Q_not=%h", i, qn4, q4, ~exp4);
      end
      // Mid-cycle, away from the edge, the value must still be held.
      #3;
      d4 = ~d4;
      #1;
      checks++;
      if (q4 !== exp4) begin
        errors++;
        $display("FAIL random_hold edge%0d: Q=%h expected %h", i, q4, exp4);
      end
    end
    @(negedge clk4);
    rst4 = 1'b0;
    $display("random run: %0d reset pulses applied", nrst);
  endtask

  initial begin
    exp1 = 1'b0;
    #10;
    test_reset();
    test_truth_table();
    test_hold();
    test_sync_reset();
    test_width4();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
